// File: rtl/input_driver.sv
// input_driver: 74HC165-style keypad scanner with debounce and a one-entry valid/ready key slot.
// Build option: define INPUT_DRIVER_DEBOUNCE_EN to enable the multi-scan debounce filter.
//
// state  | meaning
// S_LOAD | load_n low, chain captures the key switches
// S_LOW  | sr_clk low, current bit sampled on the last cycle
// S_HIGH | sr_clk high, chain shifts on the rising edge
// S_EVAL | one cycle, fold the finished scan into stable/reported
module input_driver #(
  parameter int NUM_KEYS       = 16,
  parameter int CLK_DIV        = 4,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int KEY_W         = $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sr_data,
  output logic             o_sr_clk,
  output logic             o_sr_load_n,
  output logic [KEY_W-1:0] o_key,
  output logic             o_valid,
  input  logic             i_ready
);

  if (NUM_KEYS < 2 || NUM_KEYS > 32 || CLK_DIV < 1 || DEBOUNCE_SCANS < 1) begin : g_param_check
    $error("input_driver: illegal parameter value");
  end

  typedef enum logic [1:0] {S_LOAD, S_LOW, S_HIGH, S_EVAL} state_t;

  localparam int TMR_W = $clog2(CLK_DIV + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLK_DIV - 1);
  // One extra count after reset: load_n stays high for the reset cycle itself.
  localparam logic [TMR_W-1:0] TMR_FIRST  = TMR_W'(CLK_DIV);
  localparam logic [KEY_W-1:0] LAST_BIT   = KEY_W'(NUM_KEYS - 1);

  state_t              state;
  logic [TMR_W-1:0]    tmr;
  logic [KEY_W-1:0]    bit_idx;
  logic [NUM_KEYS-1:0] scan;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_next;
  logic [NUM_KEYS-1:0] reported;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pick_mask;
  logic [KEY_W-1:0]    pick_idx;
  logic                slot_load;

`ifdef INPUT_DRIVER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [NUM_KEYS-1:0] candidate;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;

  // On a match candidate already equals scan, so scan stands in for it below.
  always_comb begin
    count_next  = '0;
    stable_next = stable;
    if (scan == candidate) begin
      count_next = (count == CNT_MAX) ? count : count + CNT_W'(1);
    end
    if (count_next == CNT_MAX) stable_next = scan;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= '0;
      count     <= '0;
    end else if (state == S_EVAL) begin
      candidate <= scan;
      count     <= count_next;
    end
  end
`else
  assign stable_next = scan;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LOAD;
      tmr         <= TMR_FIRST;
      bit_idx     <= '0;
      scan        <= '0;
      stable      <= '0;
      o_sr_clk    <= 1'b0;
      o_sr_load_n <= 1'b1;
    end else begin
      case (state)
        S_LOAD: begin
          if (tmr == '0) begin
            state       <= S_LOW;
            tmr         <= TMR_RELOAD;
            o_sr_load_n <= 1'b1;
          end else begin
            tmr         <= tmr - TMR_W'(1);
            o_sr_load_n <= 1'b0;
          end
        end
        S_LOW: begin
          if (tmr == '0) begin
            scan[bit_idx] <= i_sr_data;
            state         <= S_HIGH;
            tmr           <= TMR_RELOAD;
            o_sr_clk      <= 1'b1;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_HIGH: begin
          if (tmr == '0) begin
            tmr      <= TMR_RELOAD;
            o_sr_clk <= 1'b0;
            if (bit_idx == LAST_BIT) begin
              state   <= S_EVAL;
              bit_idx <= '0;
            end else begin
              state   <= S_LOW;
              bit_idx <= bit_idx + KEY_W'(1);
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_EVAL: begin
          stable      <= stable_next;
          state       <= S_LOAD;
          tmr         <= TMR_RELOAD;
          o_sr_load_n <= 1'b0;
        end
        default: begin
          state <= S_LOAD;
          tmr   <= TMR_RELOAD;
        end
      endcase
    end
  end

  always_comb begin
    pending   = stable & ~reported;
    pick_mask = pending & (~pending + NUM_KEYS'(1));
    pick_idx  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) pick_idx = KEY_W'(i);
    end
  end

  assign slot_load = (!o_valid || i_ready) && (pending != '0);

  // A released key drops out of reported at S_EVAL, which re-arms it for the next press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_key    <= '0;
      o_valid  <= 1'b0;
      reported <= '0;
    end else begin
      if (slot_load) begin
        o_key   <= pick_idx;
        o_valid <= 1'b1;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
      reported <= ((state == S_EVAL) ? (reported & stable_next) : reported)
                | (slot_load ? pick_mask : '0);
    end
  end

endmodule

// File: tb/tb_input_driver.sv
// Directed bench for input_driver: default 16-key chain plus a 32-key, CLK_DIV=1 instance.
// Expected timings follow the INPUT_DRIVER_DEBOUNCE_EN setting of the build.
module tb_input_driver;

  localparam int NK  = 16;
  localparam int DIV = 4;
`ifdef INPUT_DRIVER_DEBOUNCE_EN
  localparam int DEB_EFF   = 4;
  localparam int BOUNCE_EV = 0;
`else
  localparam int DEB_EFF   = 1;
  localparam int BOUNCE_EV = 3;
`endif
  localparam int PERIOD = 133;
  // S_EVAL of scan n executes at edge 1+133n; the slot loads one edge later.
  localparam int FIRST_EVENT = PERIOD * DEB_EFF + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_ready = 1'b0;
  logic [NK-1:0] keys = '0;
  logic [NK-1:0] chain = '0;
  logic          chain_clk_q = 1'b0;
  logic          o_sr_clk, o_sr_load_n, o_valid;
  logic [3:0]    o_key;

  logic [31:0]   keys2 = 32'h8000_0000;
  logic [31:0]   chain2 = '0;
  logic          chain2_clk_q = 1'b0;
  logic          ready2 = 1'b0;
  logic          o_sr_clk2, o_sr_load_n2, o_valid2;
  logic [4:0]    o_key2;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int          ev_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && o_valid && i_ready) ev_cnt <= ev_cnt + 1;

  input_driver u_dut (
    .clk(clk), .rst_n(rst_n), .i_sr_data(chain[0]), .o_sr_clk(o_sr_clk),
    .o_sr_load_n(o_sr_load_n), .o_key(o_key), .o_valid(o_valid), .i_ready(i_ready)
  );

  input_driver #(.NUM_KEYS(32), .CLK_DIV(1), .DEBOUNCE_SCANS(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_sr_data(chain2[0]), .o_sr_clk(o_sr_clk2),
    .o_sr_load_n(o_sr_load_n2), .o_key(o_key2), .o_valid(o_valid2), .i_ready(ready2)
  );

  // 74HC165 chain models: parallel load while load_n low, shift on sr_clk rise.
  always @(negedge clk) begin
    if (!o_sr_load_n) chain <= keys;
    else if (o_sr_clk && !chain_clk_q) chain <= chain >> 1;
    chain_clk_q <= o_sr_clk;
    if (!o_sr_load_n2) chain2 <= keys2;
    else if (o_sr_clk2 && !chain2_clk_q) chain2 <= chain2 >> 1;
    chain2_clk_q <= o_sr_clk2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset(output int unsigned start);
    @(negedge clk);
    rst_n = 1'b1;
    start = cyc;
  endtask

  task automatic wait_valid(input int bound, output int unsigned at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (o_valid === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic next_scan();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (o_sr_load_n === 1'b0) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (o_sr_load_n === 1'b1) begin ok = 1'b1; break; end
      end
    end
    if (!ok) check("scan_sync_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned st, at, t0, t1;
    bit ok;
    int n, e0, found;
    logic prev;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_sr_clk", o_sr_clk, 0);
    check("rst_load_n", o_sr_load_n, 1);
    check("rst_valid", o_valid, 0);
    check("rst_key", o_key, 0);

    // First load and scan period
    release_reset(st);
    tick();
    check("load_first_edge", o_sr_load_n, 0);
    n = 1;
    while (o_sr_load_n === 1'b0 && n < 50) begin tick(); n++; end
    check("load_len", n - 1, DIV);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (o_sr_load_n === 1'b0) break;
    end
    check("scan_period", cyc - st - 1, PERIOD);

    // Single press of key 5 with i_ready high
    assert_reset();
    keys = 16'h0020;
    i_ready = 1'b1;
    release_reset(st);
    wait_valid(3000, at, ok);
    check("press_found", ok, 1);
    check("press_latency", at - st, FIRST_EVENT);
    check("press_key", o_key, 5);
    tick();
    check("press_pulse", o_valid, 0);
    n = 0;
    repeat (3 * PERIOD) begin tick(); if (o_valid === 1'b1) n++; end
    check("held_no_repeat", n, 0);

    // Keys 2 and 9 together, consumer stalled then ready
    assert_reset();
    keys = 16'h0204;
    i_ready = 1'b0;
    release_reset(st);
    wait_valid(3000, at, ok);
    check("simul_found", ok, 1);
    check("simul_first_key", o_key, 2);
    repeat (20) tick();
    check("stall_valid", o_valid, 1);
    check("stall_key", o_key, 2);
    @(negedge clk) i_ready = 1'b1;
    tick();
    check("b2b_valid", o_valid, 1);
    check("b2b_key", o_key, 9);
    tick();
    check("b2b_drain", o_valid, 0);

    // Key 7: release before consume, then re-press
    assert_reset();
    keys = 16'h0080;
    i_ready = 1'b0;
    release_reset(st);
    wait_valid(3000, at, ok);
    check("k7_key", o_key, 7);
    keys = '0;
    repeat (2) next_scan();
    check("release_keeps_valid", o_valid, 1);
    check("release_keeps_key", o_key, 7);
    @(negedge clk) i_ready = 1'b1;
    tick();
    check("release_consume", o_valid, 0);
    repeat (4) next_scan();
    keys = 16'h0080;
    i_ready = 1'b0;
    wait_valid(3000, at, ok);
    check("repress_found", ok, 1);
    check("repress_key", o_key, 7);

    // Asynchronous reset mid-scan while the slot is full
    assert_reset();
    check("arst_valid", o_valid, 0);
    check("arst_key", o_key, 0);
    check("arst_sr_clk", o_sr_clk, 0);
    check("arst_load_n", o_sr_load_n, 1);
    #20;
    release_reset(st);
    wait_valid(3000, at, ok);
    check("rereport_latency", at - st, FIRST_EVENT);
    check("rereport_key", o_key, 7);

    // Key 3 bouncing on alternate scans, then held
    assert_reset();
    keys = '0;
    i_ready = 1'b1;
    release_reset(st);
    e0 = ev_cnt;
    for (int s = 0; s < 6; s++) begin
      keys[3] = (s % 2 == 0);
      next_scan();
    end
    check("bounce_events", ev_cnt - e0, BOUNCE_EV);
    keys[3] = 1'b1;
    wait_valid(3000, at, ok);
    check("bounce_found", ok, 1);
    check("bounce_key", o_key, 3);

    // 32-key chain at CLK_DIV=1 (stalled consumer keeps the event visible)
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (o_valid2 === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    check("chain_found", ok, 1);
    check("chain_key", o_key2, 31);
    prev = o_sr_load_n2;
    found = 0;
    t0 = 0;
    t1 = 0;
    for (int i = 0; i < 300 && found < 2; i++) begin
      tick();
      if (prev === 1'b1 && o_sr_load_n2 === 1'b0) begin
        if (found == 0) t0 = cyc;
        else t1 = cyc;
        found++;
      end
      prev = o_sr_load_n2;
    end
    check("chain_sync", found, 2);
    check("chain_period", t1 - t0, 66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_driver.md
# input_driver

Keypad front end: scans a chain of parallel-in/serial-out shift registers (74HC165-style) with `o_sr_clk`/`o_sr_load_n`, reading `NUM_KEYS` key switches serially on `i_sr_data`. It debounces the scanned vector, detects new presses, and hands one key code at a time to the calculator core over a valid/ready interface. It is the input-side counterpart of `output_driver`, which drives the 7-segment display shift registers.

## Interface
- `NUM_KEYS`, 16: number of key inputs in the chain; legal range 2..32.
- `CLK_DIV`, 4: system cycles per half-period of `o_sr_clk`, and the length of the load pulse; minimum 1.
- `DEBOUNCE_SCANS`, 4: consecutive identical scans required before a vector is accepted; minimum 1.
- `KEY_W`: localparam, `$clog2(NUM_KEYS)`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `i_sr_data` in 1: serial data from the chain; 1 means the key is pressed.
- `o_sr_clk` out 1: shift clock to the chain.
- `o_sr_load_n` out 1: parallel load, active-low.
- `o_key` out KEY_W: index of the pressed key.
- `o_valid` out 1: `o_key` holds an unconsumed key event.
- `i_ready` in 1: the consumer accepts the event.

## Operation
- FSM states are S_LOAD → (S_LOW → S_HIGH) × NUM_KEYS → S_EVAL → S_LOAD, looping forever.
- **S_LOAD**: `load_n`=0, `sr_clk`=0, for CLK_DIV cycles.
- **S_LOW**: `load_n`=1, `sr_clk`=0, for CLK_DIV cycles. On the last cycle, `i_sr_data` is sampled into `scan[bit]`, with bit running 0..NUM_KEYS-1. The first sampled bit is key 0.
- **S_HIGH**: `sr_clk`=1 for CLK_DIV cycles. Its rising edge shifts the chain. After bit NUM_KEYS-1, go to S_EVAL.
- **S_EVAL** (1 cycle) updates the debounce stage:
  - If `scan == candidate`, `count` increments, saturating at DEBOUNCE_SCANS-1. When `count` equals DEBOUNCE_SCANS-1, `stable <= candidate`.
  - Otherwise `candidate <= scan` and `count <= 0`.
  - `reported <= reported & stable_next`. Releasing a key re-arms it.
- `pending = stable & ~reported`. This is evaluated every cycle.
- **Output slot (one entry)**: in any cycle where `!o_valid || (o_valid && i_ready)` holds and `pending != 0`:
  - `o_key` is loaded with the lowest set index of `pending`.
  - `o_valid` is set to 1.
  - That index's bit is set in `reported`.
- If the slot is consumed and `pending == 0`, `o_valid` drops to 0.
- While `o_valid && !i_ready`, `o_key` and `o_valid` are held stable.
- A held key produces exactly one event. There is no auto-repeat.
- A key released before its event is consumed keeps its event in the slot. The event is not withdrawn.

## Timing
- **Reset values**: `o_sr_clk`=0, `o_sr_load_n`=1, `o_valid`=0, `o_key`=0. `scan`, `candidate`, `count`, `stable` and `reported` all reset to 0. The FSM resets to S_LOAD.
- **First load**: `o_sr_load_n` goes low on the first rising `clk` edge after `rst_n` deasserts.
- **Scan period**: CLK_DIV + 2·CLK_DIV·NUM_KEYS + 1 cycles, which is 133 with the defaults.
- **Press latency**: with steady input from a scan boundary, `stable` updates at the S_EVAL of the DEBOUNCE_SCANS-th scan. `o_valid` rises one cycle after that S_EVAL.
- **Back-to-back events**: with `i_ready`=1 and several pending keys, one event is delivered per cycle in ascending index order.
- **Handshake and reload in the same cycle**: the slot reloads with no bubble.
- **Reset mid-scan**: all outputs and state take their reset values immediately. Keys held through reset are reported again after a full debounce.

## Configuration
- Macro: `INPUT_DRIVER_DEBOUNCE_EN`.
- **Defined**: debounce behaves as described under Operation.
- **Undefined**: `candidate`/`count` logic is removed and `stable <= scan` at every S_EVAL. Press latency is one scan, and `DEBOUNCE_SCANS` is ignored.

## Test plan
- **Reset**: assert `rst_n`=0 mid-scan with `o_valid`=1. Outputs go to reset values asynchronously. After release, `load_n` is low for 4 cycles starting at the first edge, and the scan period is 133 cycles.
- **Single press**: press key 5 and hold; `i_ready`=1. `o_valid` pulses for one cycle with `o_key`=5, one cycle after the 4th scan's S_EVAL. No further events while the key is held.
- **Bounce**: key 3 toggles on alternate scans for 6 scans, then is held. The event appears only after 4 consecutive pressed scans. With the macro undefined, each pressed scan after a released scan yields an event.
- **Simultaneous**: press keys 2 and 9 in the same scan with `i_ready`=0. `o_key`=2 is held. When `i_ready` rises, 2 transfers, then 9 transfers on the next cycle.
- **Re-press**: press key 7, release for 4 scans, press again. This gives two events. Releasing before `i_ready` keeps `o_key`=7 valid.
- **Chain length**: with NUM_KEYS=32 and CLK_DIV=1, press key 31. The event shows `o_key`=31, and the scan period is 66 cycles.
